// File: rtl/ins_cache_pkg.sv
// Shared definitions for the instruction cache: widths, default geometry and FSM states.
package ins_cache_pkg;

    localparam int unsigned PC_LEN            = 32;
    localparam int unsigned INS_LEN           = 32;
    localparam int unsigned ICACHE_INDEX_BITS = 8;
    localparam int unsigned ICACHE_TAG_LEN    = PC_LEN - ICACHE_INDEX_BITS - 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMiss = 2'd1,
        StDrop = 2'd2
    } icache_state_e;

endpackage

// File: rtl/ins_cache_array.sv
// Storage for the direct-mapped instruction cache: valid bits, tags and one data word per line.
// Combinational read port, synchronous write port; only the valid bits are reset.
module ins_cache_array
    import ins_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int unsigned TAG_LEN    = PC_LEN - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_LEN-1:0]    rd_tag,
    output logic [INS_LEN-1:0]    rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_LEN-1:0]    wr_tag,
    input  logic [INS_LEN-1:0]    wr_data
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;

    logic [ENTRIES-1:0] valid;
    logic [TAG_LEN-1:0] tag_mem  [ENTRIES];
    logic [INS_LEN-1:0] data_mem [ENTRIES];

    // Valid bits: cleared on reset, set by every fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data lines: written on fill, never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/ins_cache.sv
// Direct-mapped instruction cache sitting between fetch and mem_ctrl.
// Hits respond one cycle after the request; misses fetch one word and bypass it to fetch.
// A jump cancels the pending response; an in-flight fill still completes and is written.
// Optional hit/miss counters are enabled by defining ICACHE_STAT_EN.
module ins_cache
    import ins_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic               jump,
    input  logic               fetch_req,
    input  logic [PC_LEN-1:0]  fetch_pc,
    output logic               fetch_rdy,
    output logic [INS_LEN-1:0] fetch_ins,
    output logic               mem_req,
    output logic [PC_LEN-1:0]  mem_addr,
`ifdef ICACHE_STAT_EN
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt,
`endif
    input  logic               mem_done,
    input  logic [INS_LEN-1:0] mem_data
);

    localparam int unsigned TAG_LEN = PC_LEN - INDEX_BITS - 2;

    icache_state_e state;

    logic                  rd_valid;
    logic [TAG_LEN-1:0]    rd_tag;
    logic [INS_LEN-1:0]    rd_data;
    logic                  we;
    logic                  lookup;
    logic                  lookup_hit;
    logic                  lookup_miss;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^fetch_pc[1:0];

    // mem_addr doubles as the latched miss PC, so fills index and tag from it.
    assign we = ready && mem_done && (state == StMiss || state == StDrop);

    // A lookup happens only in IDLE, off cooldown, with no redirect.
    assign lookup      = ready && (state == StIdle) && fetch_req && !jump && !fetch_rdy;
    assign lookup_hit  = lookup && rd_valid && (rd_tag == fetch_pc[PC_LEN-1:INDEX_BITS+2]);
    assign lookup_miss = lookup && !lookup_hit;

    ins_cache_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_LEN   (TAG_LEN)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (fetch_pc[INDEX_BITS+1:2]),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (we),
        .wr_idx  (mem_addr[INDEX_BITS+1:2]),
        .wr_tag  (mem_addr[PC_LEN-1:INDEX_BITS+2]),
        .wr_data (mem_data)
    );

    // Control FSM with registered fetch/mem outputs; ready=0 freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            fetch_rdy <= 1'b0;
            fetch_ins <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else if (ready) begin
            unique case (state)
                StIdle: begin
                    // fetch_rdy=1 means fetch's request level is stale this cycle.
                    if (jump || fetch_rdy) begin
                        fetch_rdy <= 1'b0;
                    end else if (lookup_hit) begin
                        fetch_rdy <= 1'b1;
                        fetch_ins <= rd_data;
                    end else if (lookup_miss) begin
                        mem_req  <= 1'b1;
                        mem_addr <= {fetch_pc[PC_LEN-1:2], 2'b00};
                        state    <= StMiss;
                    end
                end
                StMiss: begin
                    fetch_rdy <= 1'b0;
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        state   <= StIdle;
                        if (!jump) begin
                            fetch_rdy <= 1'b1;
                            fetch_ins <= mem_data;
                        end
                    end else if (jump) begin
                        // mem_ctrl cannot abort; keep mem_req up and swallow the fill.
                        state <= StDrop;
                    end
                end
                StDrop: begin
                    fetch_rdy <= 1'b0;
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef ICACHE_STAT_EN
    // Hit/miss statistics; a miss counts on entry even if a jump later drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (lookup_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (lookup_miss) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ins_cache.sv
// Self-checking bench for ins_cache: directed scenarios then randomized traffic.
// Expected responses go into a queue; a negedge monitor pops them when fetch_rdy pulses.
// Set ICACHE_STAT_EN when compiling to also check the statistics counters.
module tb_ins_cache;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        jump;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_rdy;
    logic [31:0] fetch_ins;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int tests    = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    bit          mvalid [256];
    logic [21:0] mtag   [256];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    ins_cache u_dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .jump     (jump),
        .fetch_req(fetch_req),
        .fetch_pc (fetch_pc),
        .fetch_rdy(fetch_rdy),
        .fetch_ins(fetch_ins),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
`ifdef ICACHE_STAT_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .mem_done (mem_done),
        .mem_data (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Backing memory contents seen by the cache.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0) return 32'h0000_0013;
        return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch transaction; jmode issues a jump (with the request on a hit, or jlead
    // cycles before mem_done on a miss); rgap stalls with ready=0 and a bogus mem_done.
    task automatic do_fetch(input logic [31:0] pc, input bit jmode, input int jlead,
                            input int lat, input bit rgap);
        int          idx;
        logic [21:0] tg;
        bit          hit;
        idx = int'(pc[9:2]);
        tg  = pc[31:10];
        hit = mvalid[idx] && (mtag[idx] == tg);
        fetch_pc  = pc;
        fetch_req = 1'b1;
        if (hit) begin
            if (jmode) begin
                jump = 1'b1;
                step();
                jump      = 1'b0;
                fetch_req = 1'b0;
                check("jump_idle_rdy", 32'(fetch_rdy), 32'd0);
                check("jump_idle_memreq", 32'(mem_req), 32'd0);
            end else begin
                exp_q.push_back(mem_word(pc));
                exp_hits++;
                step();
                check("hit_rdy", 32'(fetch_rdy), 32'd1);
                check("hit_memreq", 32'(mem_req), 32'd0);
                step();
                fetch_req = 1'b0;
                check("cooldown_rdy", 32'(fetch_rdy), 32'd0);
            end
            return;
        end
        exp_misses++;
        if (!jmode) exp_q.push_back(mem_word(pc));
        step();
        check("miss_memreq", 32'(mem_req), 32'd1);
        check("miss_addr", mem_addr, {pc[31:2], 2'b00});
        check("miss_rdy", 32'(fetch_rdy), 32'd0);
        if (rgap) begin
            ready    = 1'b0;
            mem_done = 1'b1;
            mem_data = ~mem_word(pc);
            step();
            check("stall_memreq", 32'(mem_req), 32'd1);
            check("stall_rdy", 32'(fetch_rdy), 32'd0);
            check("stall_addr", mem_addr, {pc[31:2], 2'b00});
            mem_done = 1'b0;
            ready    = 1'b1;
        end
        for (int c = 0; c <= lat; c++) begin
            if (jmode && c == lat - jlead) begin
                jump      = 1'b1;
                fetch_req = 1'b0;
            end
            if (c == lat) begin
                mem_done = 1'b1;
                mem_data = mem_word(pc);
            end
            step();
            jump     = 1'b0;
            mem_done = 1'b0;
            if (c < lat) begin
                check("wait_rdy", 32'(fetch_rdy), 32'd0);
                check("wait_memreq", 32'(mem_req), 32'd1);
            end
        end
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        check("fill_memreq", 32'(mem_req), 32'd0);
        if (!jmode) begin
            check("fill_rdy", 32'(fetch_rdy), 32'd1);
            step();
            fetch_req = 1'b0;
            check("cooldown_rdy", 32'(fetch_rdy), 32'd0);
        end else begin
            check("drop_rdy", 32'(fetch_rdy), 32'd0);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && fetch_rdy) begin
            if (exp_q.size() == 0) begin
                tests++;
                failures++;
                $display("FAIL unexpected_rdy: got ins %h, required no response", fetch_ins);
            end else begin
                check("resp_ins", fetch_ins, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] tag_set [4];
        logic [3:0]  pat;
        logic [31:0] pc;
        int          lat;
        tag_set = '{22'h000000, 22'h000001, 22'h3FFFFF, 22'h2AAAAA};
        for (int i = 0; i < 256; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end
        reset     = 1'b1;
        ready     = 1'b1;
        jump      = 1'b0;
        fetch_req = 1'b0;
        fetch_pc  = '0;
        mem_done  = 1'b0;
        mem_data  = '0;
        repeat (3) step();
        reset = 1'b0;
        check("reset_rdy", 32'(fetch_rdy), 32'd0);
        check("reset_ins", fetch_ins, 32'd0);
        check("reset_memreq", 32'(mem_req), 32'd0);
        check("reset_addr", mem_addr, 32'd0);
`ifdef ICACHE_STAT_EN
        check("reset_hit_cnt", hit_cnt, 32'd0);
        check("reset_miss_cnt", miss_cnt, 32'd0);
`endif
        step();

        // Cold miss, hit, then a conflicting line evicting pc 0.
        do_fetch(32'h0, 1'b0, 0, 3, 1'b0);
        do_fetch(32'h0, 1'b0, 0, 0, 1'b0);
        do_fetch(32'h400, 1'b0, 0, 2, 1'b0);
        do_fetch(32'h0, 1'b0, 0, 1, 1'b0);
`ifdef ICACHE_STAT_EN
        check("dir_hit_cnt", hit_cnt, 32'd1);
        check("dir_miss_cnt", miss_cnt, 32'd3);
`endif

        // Jump one cycle before mem_done: no response, line still filled.
        do_fetch(32'h8, 1'b1, 1, 3, 1'b0);
        do_fetch(32'h8, 1'b0, 0, 0, 1'b0);

        // Request level held for four cycles on a hit.
        fetch_pc  = 32'h8;
        fetch_req = 1'b1;
        exp_q.push_back(mem_word(32'h8));
        exp_q.push_back(mem_word(32'h8));
        exp_hits += 2;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            pat = {pat[2:0], fetch_rdy};
        end
        fetch_req = 1'b0;
        check("held_pattern", 32'(pat), 32'h0000_000A);

        // ready=0 during a miss with a bogus mem_done pulse.
        do_fetch(32'h10, 1'b0, 0, 4, 1'b1);

        // Randomized traffic over a few tags and indices.
        for (int n = 0; n < 300; n++) begin
            pc  = {tag_set[$urandom_range(0, 3)], 8'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3))};
            lat = int'($urandom_range(0, 5));
            do_fetch(pc, ($urandom_range(0, 3) == 0), int'($urandom_range(0, lat)), lat,
                     ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (4) step();
        check("leftover_expected", 32'(exp_q.size()), 32'd0);
`ifdef ICACHE_STAT_EN
        check("final_hit_cnt", hit_cnt, 32'(exp_hits));
        check("final_miss_cnt", miss_cnt, 32'(exp_misses));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
